// File: rtl/fc_pkg.sv
// Shared definitions for the FC vector writer: width defaults and FSM states.
package fc_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned RES_W_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } fc_state_e;

endpackage

// File: rtl/fc_vector_writer.sv
// Loads a sample vector into memory, starts the FC engine, and holds its
// argmax result until the consumer acknowledges it.
module fc_vector_writer
    import fc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RES_W  = RES_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [ADDR_W-1:0] base_address,
    input  logic [ADDR_W-1:0] length,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_write_en,
    output logic              fc_start,
    input  logic              fc_done,
    input  logic [RES_W-1:0]  fc_result,
    output logic              result_valid,
    output logic [RES_W-1:0]  result,
    input  logic              result_ack,
    output logic              busy
);

    fc_state_e         state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] count;
    logic              fc_done_q;

    // Run sequencer: all outputs are registered and updated alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            count        <= '0;
            fc_done_q    <= 1'b0;
            in_ready     <= 1'b0;
            mem_address  <= '0;
            mem_data     <= '0;
            mem_write_en <= 1'b0;
            fc_start     <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            busy         <= 1'b0;
        end else begin
            fc_done_q    <= fc_done;
            mem_write_en <= 1'b0;
            fc_start     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go && (length != '0)) begin
                        base_q   <= base_address;
                        len_q    <= length;
                        count    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        mem_write_en <= 1'b1;
                        mem_address  <= base_q + count;
                        mem_data     <= in_data;
                        count        <= count + ADDR_W'(1);
                        if (count == len_q - ADDR_W'(1)) begin
                            in_ready <= 1'b0;
                            state    <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    fc_start <= 1'b1;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Only a fresh rise counts; a level left high from before
                    // the start pulse is ignored.
                    if (fc_done && !fc_done_q) begin
                        result       <= fc_result;
                        result_valid <= 1'b1;
                        state        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready     <= 1'b0;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
